// File: rtl/e_mdu_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module e_mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [4:0] MC = 5'(MULT_CYCLES);
  localparam logic [4:0] DC = 5'(DIV_CYCLES);

  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic        pwr_q, pwr_d;
  logic [3:0]  op_e;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvs;
  logic signed [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;
  logic        dv_ovf;

  always_comb begin
    op_e = op;
`ifdef MDU_MADD_EN
    if (op > 4'd12) op_e = OP_NONE;
`else
    if (op > 4'd8) op_e = OP_NONE;
`endif
  end

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data})
                * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Zero and MIN/-1 divisors are steered to 1: the first result is discarded,
  // the second then yields the wrapped quotient MIN with remainder 0.
  assign dv_ovf = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
  assign dvs    = (rt_data == 32'd0 || dv_ovf) ? 32'd1 : rt_data;
  assign q_s    = $signed(rs_data) / $signed(dvs);
  assign r_s    = $signed(rs_data) % $signed(dvs);
  assign q_u    = rs_data / dvs;
  assign r_u    = rs_data % dvs;

  assign busy = (cnt_q != 5'd0);

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    pwr_d = pwr_q;
    if (busy) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1 && pwr_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (start) begin
      unique case (op_e)
        OP_MULT: begin
          {phi_d, plo_d} = prod_s;
          pwr_d = 1'b1;
          cnt_d = MC;
        end
        OP_MULTU: begin
          {phi_d, plo_d} = prod_u;
          pwr_d = 1'b1;
          cnt_d = MC;
        end
        OP_DIV: begin
          {phi_d, plo_d} = {r_s, q_s};
          pwr_d = (rt_data != 32'd0);
          cnt_d = DC;
        end
        OP_DIVU: begin
          {phi_d, plo_d} = {r_u, q_u};
          pwr_d = (rt_data != 32'd0);
          cnt_d = DC;
        end
        OP_MTHI: hi_d = rs_data;
        OP_MTLO: lo_d = rs_data;
`ifdef MDU_MADD_EN
        OP_MADD: begin
          {phi_d, plo_d} = {hi_q, lo_q} + prod_s;
          pwr_d = 1'b1;
          cnt_d = MC;
        end
        OP_MADDU: begin
          {phi_d, plo_d} = {hi_q, lo_q} + prod_u;
          pwr_d = 1'b1;
          cnt_d = MC;
        end
        OP_MSUB: begin
          {phi_d, plo_d} = {hi_q, lo_q} - prod_s;
          pwr_d = 1'b1;
          cnt_d = MC;
        end
        OP_MSUBU: begin
          {phi_d, plo_d} = {hi_q, lo_q} - prod_u;
          pwr_d = 1'b1;
          cnt_d = MC;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 5'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      phi_q <= 32'd0;
      plo_q <= 32'd0;
      pwr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwr_q <= pwr_d;
    end
  end

  assign md_stall = busy && start && (op_e != OP_NONE);
  assign rd_data  = (start && op_e == OP_MFHI) ? hi_q :
                    (start && op_e == OP_MFLO) ? lo_q : 32'd0;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
